// File: rtl/xbus_mem_slave.sv
// xbus_mem_slave: single-port XBUS slave with a word-addressed, byte-writable
// memory, programmable wait states and a base-address window.
//
// Ports:
//   clk        system clock
//   rstn       synchronous active-low reset
//   xbs_select transfer request, held until ack is seen
//   xbs_addr   byte address (bits [1:0] ignored)
//   xbs_data   write data
//   xbs_rnw    1 = read, 0 = write
//   xbs_be     byte enables, be[i] selects data[8i+7:8i]
//   sl_ack     one-cycle transfer-complete pulse
//   sl_data    read data, zero outside the ack cycle
//   err_cnt    saturating count of out-of-window accesses
module xbus_mem_slave #(
    parameter int          AW          = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] MISS_DATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        xbs_select,
    input  logic [31:0] xbs_addr,
    input  logic [31:0] xbs_data,
    input  logic        xbs_rnw,
    input  logic [3:0]  xbs_be,
    output logic        sl_ack,
    output logic [31:0] sl_data,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_DONE
    } state_t;

    localparam bit         NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] cap_idx;
    logic [31:0]   cap_data;
    logic          cap_rnw;
    logic [3:0]    cap_be;
    logic          cap_hit;

    logic [31:0]   mem [0:(1<<AW)-1];

    logic          req_hit;
    logic [AW-1:0] req_idx;

    logic          access;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_data;
    logic          acc_rnw;
    logic [3:0]    acc_be;
    logic          acc_hit;

    logic          unused_addr;

    assign unused_addr = ^xbs_addr[1:0];

    assign req_hit = (xbs_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign req_idx = xbs_addr[AW+1:2];

    // With zero wait states the access happens on the capture edge itself,
    // so it must use the live bus values instead of the captured copies.
    always_comb begin
        access   = 1'b0;
        acc_idx  = cap_idx;
        acc_data = cap_data;
        acc_rnw  = cap_rnw;
        acc_be   = cap_be;
        acc_hit  = cap_hit;
        if (state == ST_IDLE) begin
            access   = NO_WAIT && xbs_select;
            acc_idx  = req_idx;
            acc_data = xbs_data;
            acc_rnw  = xbs_rnw;
            acc_be   = xbs_be;
            acc_hit  = req_hit;
        end else if (state == ST_WAIT) begin
            access = (cnt == 4'd1);
        end
        if (!rstn) begin
            access = 1'b0;
        end
    end

    // Memory is deliberately not reset; writes are gated by rstn above.
    always_ff @(posedge clk) begin
        if (access && acc_hit && !acc_rnw) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            sl_ack   <= 1'b0;
            sl_data  <= 32'd0;
            err_cnt  <= 16'd0;
            cap_idx  <= '0;
            cap_data <= 32'd0;
            cap_rnw  <= 1'b0;
            cap_be   <= 4'd0;
            cap_hit  <= 1'b0;
        end else begin
            sl_ack  <= 1'b0;
            sl_data <= 32'd0;

            if (access) begin
                sl_ack <= 1'b1;
                if (acc_hit) begin
                    sl_data <= acc_rnw ? mem[acc_idx] : 32'd0;
                end else begin
                    sl_data <= acc_rnw ? MISS_DATA : 32'd0;
                    if (err_cnt != 16'hFFFF) begin
                        err_cnt <= err_cnt + 16'd1;
                    end
                end
            end

            unique case (state)
                ST_IDLE: begin
                    if (xbs_select) begin
                        cap_idx  <= req_idx;
                        cap_data <= xbs_data;
                        cap_rnw  <= xbs_rnw;
                        cap_be   <= xbs_be;
                        cap_hit  <= req_hit;
                        if (NO_WAIT) begin
                            state <= ST_ACK;
                        end else begin
                            cnt   <= WAIT_LD;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd1) begin
                        cnt   <= 4'd0;
                        state <= ST_ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    // A held request must not retrigger a second access.
                    if (!xbs_select) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xbus_mem_slave.sv
// tb_xbus_mem_slave: scoreboard bench for xbus_mem_slave.
// Instance 0 uses two wait states, instance 1 uses zero wait states.
module tb_xbus_mem_slave;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        sel  [2];
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic        rnw  [2];
    logic [3:0]  be   [2];
    logic        ack  [2];
    logic [31:0] rdat [2];
    logic [15:0] ecnt [2];

    exp_t q0 [$];
    exp_t q1 [$];
    int   cyc;
    int   n_chk;
    int   n_fail;
    bit   ready;

    exp_t m_e;
    bit   m_have;

    xbus_mem_slave #(.WAIT_CYCLES(2)) u_dut0 (
        .clk        (clk),
        .rstn       (rstn),
        .xbs_select (sel[0]),
        .xbs_addr   (addr[0]),
        .xbs_data   (wdat[0]),
        .xbs_rnw    (rnw[0]),
        .xbs_be     (be[0]),
        .sl_ack     (ack[0]),
        .sl_data    (rdat[0]),
        .err_cnt    (ecnt[0])
    );

    xbus_mem_slave #(.WAIT_CYCLES(0)) u_dut1 (
        .clk        (clk),
        .rstn       (rstn),
        .xbs_select (sel[1]),
        .xbs_addr   (addr[1]),
        .xbs_data   (wdat[1]),
        .xbs_rnw    (rnw[1]),
        .xbs_be     (be[1]),
        .sl_ack     (ack[1]),
        .sl_data    (rdat[1]),
        .err_cnt    (ecnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expectation per ack, checks data and arrival cycle.
    always @(negedge clk) begin
        if (ready) begin
            for (int d = 0; d < 2; d++) begin
                if (ack[d]) begin
                    m_have = 1'b0;
                    if (d == 0 && q0.size() > 0) begin
                        m_e = q0.pop_front();
                        m_have = 1'b1;
                    end
                    if (d == 1 && q1.size() > 0) begin
                        m_e = q1.pop_front();
                        m_have = 1'b1;
                    end
                    n_chk++;
                    if (!m_have) begin
                        n_fail++;
                        $display("FAIL unexpected_ack dut%0d cyc=%0d got ack=1 required ack=0",
                                 d, cyc);
                    end else begin
                        if (rdat[d] !== m_e.data) begin
                            n_fail++;
                            $display("FAIL ack_data dut%0d got %h required %h",
                                     d, rdat[d], m_e.data);
                        end
                        n_chk++;
                        if (cyc != m_e.cyc) begin
                            n_fail++;
                            $display("FAIL ack_latency dut%0d got cyc %0d required cyc %0d",
                                     d, cyc, m_e.cyc);
                        end
                    end
                end else begin
                    n_chk++;
                    if (rdat[d] !== 32'd0) begin
                        n_fail++;
                        $display("FAIL idle_data dut%0d got %h required 0", d, rdat[d]);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got %h required %h", nm, act, req);
        end
    endtask

    task automatic xfer(input int d, input logic [31:0] a,
                        input logic [31:0] wd, input logic r,
                        input logic [3:0] b, input logic [31:0] ed,
                        input int hold);
        exp_t e;
        bit   got;
        @(negedge clk);
        addr[d] = a;
        wdat[d] = wd;
        rnw[d]  = r;
        be[d]   = b;
        sel[d]  = 1'b1;
        e.data  = ed;
        e.cyc   = cyc + 1 + ((d == 0) ? 2 : 0);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 32 && !got; i++) begin
            @(negedge clk);
            if (ack[d]) got = 1'b1;
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout dut%0d addr %h got no ack required ack", d, a);
            if (d == 0 && q0.size() > 0) void'(q0.pop_back());
            if (d == 1 && q1.size() > 0) void'(q1.pop_back());
        end
        repeat (hold) @(negedge clk);
        sel[d] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        ready  = 1'b0;
        rstn   = 1'b0;
        for (int d = 0; d < 2; d++) begin
            sel[d]  = 1'b0;
            addr[d] = 32'd0;
            wdat[d] = 32'd0;
            rnw[d]  = 1'b0;
            be[d]   = 4'd0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_ack", {31'd0, ack[d]}, 32'd0);
            chk("reset_data", rdat[d], 32'd0);
            chk("reset_err", {16'd0, ecnt[d]}, 32'd0);
        end
        rstn  = 1'b1;
        ready = 1'b1;

        // Basic write/read with two wait states
        xfer(0, 32'h10, 32'hA5A5_5A5A, 1'b0, 4'hF, 32'd0, 0);
        xfer(0, 32'h10, 32'd0, 1'b1, 4'hF, 32'hA5A5_5A5A, 0);

        // Byte lanes
        xfer(0, 32'h20, 32'h1122_3344, 1'b0, 4'hF, 32'd0, 0);
        xfer(0, 32'h20, 32'hFFFF_FFFF, 1'b0, 4'b0101, 32'd0, 0);
        xfer(0, 32'h20, 32'd0, 1'b1, 4'hF, 32'h11FF_33FF, 0);
        xfer(0, 32'h20, 32'h0, 1'b0, 4'b0000, 32'd0, 0);
        xfer(0, 32'h20, 32'd0, 1'b1, 4'hF, 32'h11FF_33FF, 0);

        // Window miss, word 0 must survive the write miss
        xfer(0, 32'h0, 32'h1234_5678, 1'b0, 4'hF, 32'd0, 0);
        xfer(0, 32'h400, 32'd0, 1'b1, 4'hF, 32'hDEAD_BEEF, 0);
        chk("err_cnt_1", {16'd0, ecnt[0]}, 32'd1);
        xfer(0, 32'h400, 32'hFFFF_FFFF, 1'b0, 4'hF, 32'd0, 0);
        chk("err_cnt_2", {16'd0, ecnt[0]}, 32'd2);
        xfer(0, 32'h0, 32'd0, 1'b1, 4'hF, 32'h1234_5678, 0);

        // Held select: one ack only, then a normal request
        xfer(0, 32'h44, 32'h0000_0001, 1'b0, 4'hF, 32'd0, 10);
        xfer(0, 32'h44, 32'd0, 1'b1, 4'hF, 32'h0000_0001, 0);
        xfer(0, 32'h30, 32'h0, 1'b0, 4'hF, 32'd0, 0);

        // Zero wait states, back-to-back
        xfer(1, 32'h40, 32'h0BAD_F00D, 1'b0, 4'hF, 32'd0, 0);
        xfer(1, 32'h40, 32'd0, 1'b1, 4'hF, 32'h0BAD_F00D, 0);
        xfer(1, 32'h40, 32'h600D_CAFE, 1'b0, 4'b0011, 32'd0, 0);
        xfer(1, 32'h40, 32'd0, 1'b1, 4'hF, 32'h0BAD_CAFE, 0);
        xfer(1, 32'h800, 32'd0, 1'b1, 4'hF, 32'hDEAD_BEEF, 0);
        chk("err_cnt_w0", {16'd0, ecnt[1]}, 32'd1);

        // Reset in WAIT abandons the write
        @(negedge clk);
        addr[0] = 32'h30;
        wdat[0] = 32'hCAFE_F00D;
        rnw[0]  = 1'b0;
        be[0]   = 4'hF;
        sel[0]  = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        sel[0] = 1'b0;
        rstn   = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_ack", {31'd0, ack[0]}, 32'd0);
        chk("rst_err", {16'd0, ecnt[0]}, 32'd0);
        xfer(0, 32'h30, 32'd0, 1'b1, 4'hF, 32'h0, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", q0.size() + q1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
